reg_scoreboard: RTL

Register-file scoreboard and issue controller for the Y86-64 pipelined core. It sits between fetch/decode and the register file. It derives each instruction's source registers from its icode, holds decode while any source has an outstanding write, and tracks in-flight destination writes with per-register counters. Write-back and squash ports release those writes. It also provides a drain sequence for halts and exceptions.

---
 rtl/reg_scoreboard_if.sv | 56 +++++
 rtl/reg_scoreboard.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard_if
//  Description : Bundle of decode, write-back, squash, drain and status signals
//                exchanged between the Y86-64 pipeline and the register-file
//                scoreboard.
//                  master - pipeline side (drives instructions, releases, drain)
//                  slave  - scoreboard side (drives id_ready, drain_done,
//                           busy_mask, stall_cnt)
//  Parameters  : NREG - number of tracked architectural registers
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if #(
   parameter int NREG = 15
);
   // decode / issue
   logic            id_valid;
   logic [3:0]      id_icode;
   logic [3:0]      id_rA;
   logic [3:0]      id_rB;
   logic [3:0]      id_dstE;
   logic [3:0]      id_dstM;
   logic            id_ready;
   // write-back releases
   logic            wb_e_valid;
   logic            wb_m_valid;
   logic [3:0]      wb_e_reg;
   logic [3:0]      wb_m_reg;
   // squash releases
   logic            sq_e_valid;
   logic            sq_m_valid;
   logic [3:0]      sq_e_reg;
   logic [3:0]      sq_m_reg;
   // drain control and status
   logic            drain_req;
   logic            drain_done;
   logic [NREG-1:0] busy_mask;
   logic [31:0]     stall_cnt;

   modport master (
      output id_valid, id_icode, id_rA, id_rB, id_dstE, id_dstM,
      output wb_e_valid, wb_m_valid, wb_e_reg, wb_m_reg,
      output sq_e_valid, sq_m_valid, sq_e_reg, sq_m_reg,
      output drain_req,
      input  id_ready, drain_done, busy_mask, stall_cnt
   );

   modport slave (
      input  id_valid, id_icode, id_rA, id_rB, id_dstE, id_dstM,
      input  wb_e_valid, wb_m_valid, wb_e_reg, wb_m_reg,
      input  sq_e_valid, sq_m_valid, sq_e_reg, sq_m_reg,
      input  drain_req,
      output id_ready, drain_done, busy_mask, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Register-file scoreboard and issue controller for the Y86-64
//                pipelined core. Derives source registers from the icode,
//                stalls decode while a source has an outstanding write, and
//                counts in-flight destination writes per register. Write-back
//                and squash ports release writes; a RUN/DRAIN/DONE sequence
//                supports halts and exceptions.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                sb       - reg_scoreboard_if.slave (decode, wb, squash, drain,
//                           id_ready, drain_done, busy_mask, stall_cnt)
//  Parameters  : SBW  - per-register counter width (max 2^SBW-1 in flight)
//                NREG - tracked registers, IDs 0..NREG-1 (NREG <= 15, ID F
//                       means "no register")
//  Macros      : REG_SB_BYPASS_EN - a source with exactly one pending write
//                that is being written back this cycle is not treated as busy
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
   parameter int SBW  = 2,
   parameter int NREG = 15
) (
   input logic              clk,
   input logic              rst_n,
   reg_scoreboard_if.slave  sb
);

   localparam logic [SBW+1:0] CNT_MAX = (SBW+2)'((1 << SBW) - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [SBW-1:0]  cnt      [NREG];
   logic [SBW-1:0]  cnt_next [NREG];
   logic [NREG-1:0] busy_q;
   logic [31:0]     stall_q;
   logic            done_q;

   logic [3:0]      src_a;
   logic [3:0]      src_b;
   logic [NREG-1:0] busy_eff;
   logic [15:0]     busy_pad;
   logic [NREG-1:0] ovf_vec;
   logic [NREG-1:0] underflow_vec;
   logic [NREG-1:0] nz_next;
   logic            hazard;
   logic            overflow;
   logic            ready;
   logic            issue;

   // ------------------------------------------------------------------------
   // Source register derivation from icode
   // ------------------------------------------------------------------------
   always_comb begin
      src_a = 4'hF;
      src_b = 4'hF;
      case (sb.id_icode)
         4'h2: src_a = sb.id_rA;                              // cmovxx
         4'h4,
         4'h6: begin src_a = sb.id_rA; src_b = sb.id_rB; end // rmmovq, OPq
         4'h5: src_b = sb.id_rB;                              // mrmovq
         4'h8: src_b = 4'h4;                                  // call
         4'h9,
         4'hB: begin src_a = 4'h4; src_b = 4'h4; end         // ret, popq
         4'hA: begin src_a = sb.id_rA; src_b = 4'h4; end     // pushq
         default: begin src_a = 4'hF; src_b = 4'hF; end
      endcase
   end

   // ------------------------------------------------------------------------
   // Per-register counter next-state, busy and overflow terms
   // ------------------------------------------------------------------------
   for (genvar r = 0; r < NREG; r++) begin : g_reg
      localparam logic [3:0] RID = 4'(r);

      logic [1:0]     inc_cand;
      logic [1:0]     inc;
      logic [2:0]     dec;
      logic [SBW+1:0] sum;

      // increment this instruction would apply if it issued
      assign inc_cand = 2'(sb.id_dstE == RID) + 2'(sb.id_dstM == RID);
      assign inc      = issue ? inc_cand : 2'd0;
      assign dec      = 3'(sb.wb_e_valid && (sb.wb_e_reg == RID))
                      + 3'(sb.wb_m_valid && (sb.wb_m_reg == RID))
                      + 3'(sb.sq_e_valid && (sb.sq_e_reg == RID))
                      + 3'(sb.sq_m_valid && (sb.sq_m_reg == RID));
      assign sum      = (SBW+2)'(cnt[r]) + (SBW+2)'(inc);

      // overflow is judged on the candidate increment so id_ready does not
      // depend on itself through issue
      assign ovf_vec[r]       = ((SBW+2)'(cnt[r]) + (SBW+2)'(inc_cand)) > CNT_MAX;
      // releasing more than is outstanding is a protocol error; hold at zero
      assign underflow_vec[r] = (SBW+2)'(dec) > sum;
      assign cnt_next[r]      = underflow_vec[r] ? '0 : SBW'(sum - (SBW+2)'(dec));
      assign nz_next[r]       = (cnt_next[r] != '0);

`ifdef REG_SB_BYPASS_EN
      logic wb_hit;
      // only write-back ports forward; squash releases never bypass
      assign wb_hit      = (sb.wb_e_valid && (sb.wb_e_reg == RID))
                        || (sb.wb_m_valid && (sb.wb_m_reg == RID));
      assign busy_eff[r] = (cnt[r] != '0) && !((cnt[r] == SBW'(1)) && wb_hit);
`else
      assign busy_eff[r] = (cnt[r] != '0);
`endif
   end

   // Pad to 16 entries so ID F (and any unused ID) looks up as never busy.
   assign busy_pad = 16'(busy_eff);
   assign hazard   = busy_pad[src_a] | busy_pad[src_b];
   assign overflow = |ovf_vec;
   assign ready    = (state == ST_RUN) && !hazard && !overflow;
   assign issue    = sb.id_valid && ready;

   // ------------------------------------------------------------------------
   // Counters, status registers and drain FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         busy_q  <= '0;
         stall_q <= '0;
         done_q  <= 1'b0;
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= cnt_next[r];
         end
         busy_q <= nz_next;
         if (sb.id_valid && !ready) begin
            stall_q <= stall_q + 32'd1;
         end
         case (state)
            ST_RUN: begin
               if (sb.drain_req) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!sb.drain_req) begin
                  state <= ST_RUN;
               end else if (nz_next == '0) begin
                  // judged on post-update counters so a same-cycle release
                  // of the last write completes the drain
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!sb.drain_req) begin
                  state  <= ST_RUN;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_RUN;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign sb.id_ready   = ready;
   assign sb.busy_mask  = busy_q;
   assign sb.stall_cnt  = stall_q;
   assign sb.drain_done = done_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (underflow_vec == '0)
            else $error("reg_scoreboard: release of a register with no write in flight");
      end
   end
`endif

endmodule
`default_nettype wire
